exposure_sequencer: RTL and testbench
=====================================

# exposure_sequencer

Parametrised exposure controller for the pixel-array front end: it sequences the Erase, Expose and row-readout phases of the sensor and generates the ADC sample strobes. It replaces the fixed 2-row, 3-state controller with a configurable row count, a prescaled exposure counter and single-shot or continuous modes. Exposure length is adjusted with Exp_Inc and Exp_Dec, and the value is held in a saturating register. The block sits between the user-button debouncers and the pixel array/ADC interface.

## Interface
- N_ROWS, 2: number of pixel rows read out; 1..16.
- EXP_W, 5: width of Exp_Time.
- EXP_MIN, 2: lower saturation limit of Exp_Time.
- EXP_MAX, 30: upper saturation limit of Exp_Time; must be < 2**EXP_W.
- EXP_DEFAULT, 2: reset value of Exp_Time; EXP_MIN..EXP_MAX.
- EXP_STEP, 1: increment and decrement step.
- TICK_DIV, 4: clock cycles per exposure unit; at least 1.
- ERASE_CYC, 4: length of the erase phase in cycles; at least 1.
- ROW_CYC, 4: cycles per row readout slot; at least 3.

Ports, clock and reset first:
- Clk  in  1  clock.
- Reset  in  1  reset, synchronous, active-high.
- Init  in  1  start request, level-sensed.
- Cont  in  1  1 = continuous mode, 0 = single shot; sampled at the end of readout.
- Exp_Inc  in  1  increase exposure; rising-edge-sensed.
- Exp_Dec  in  1  decrease exposure; rising-edge-sensed.
- Erase  out  1  pixel erase, active-high.
- Expose  out  1  pixel exposure, active-high.
- NRE  out  N_ROWS  row read enables, active-low, one-hot-low.
- ADC  out  1  ADC sample strobe, active-high.
- Done  out  1  one-cycle pulse at the end of a frame.
- Busy  out  1  high whenever state is not IDLE.
- Exp_Time  out  EXP_W  current exposure setting.

## Operation
- States: IDLE, ERASE, EXPOSE, READOUT.
- IDLE → ERASE when Init=1.
- ERASE → EXPOSE after ERASE_CYC cycles.
- EXPOSE → READOUT after Exp_Time*TICK_DIV cycles.
- READOUT → ERASE if Cont=1, otherwise → IDLE. The transition happens after N_ROWS*ROW_CYC cycles.
- In READOUT, row r occupies slot r, with r ascending from 0. Within slot cycle k (0..ROW_CYC-1):
  - NRE[r]=0 for all k; all other NRE bits are 1.
  - ADC=1 for k = 1..ROW_CYC-2.
- Erase=1 only in ERASE. Expose=1 only in EXPOSE.
- Exp_Time updates only in IDLE, on a detected rising edge:
  - Exp_Inc adds EXP_STEP. Exp_Dec subtracts EXP_STEP.
  - Results saturate at EXP_MAX and EXP_MIN; compute with one extra bit so there is no wrap.
  - Inc and Dec edges in the same cycle produce no change.
  - Edges detected outside IDLE are discarded.
- The edge-detect history registers reset to 1, so a button held through reset produces no step.
- Exp_Time is copied into the exposure counter on entry to EXPOSE. The frame length therefore cannot change mid-frame.

## Timing
- All outputs are registered and change on the same edge as the state register.
- Reset values: state IDLE, Erase=0, Expose=0, NRE=all 1, ADC=0, Done=0, Busy=0, Exp_Time=EXP_DEFAULT.
- Reset in any state: IDLE on the next edge; all counters cleared; no Done pulse.
- If Init is sampled at edge n, Erase=1 from edge n for ERASE_CYC cycles.
- Frame latency from the Init edge to Done=1 is ERASE_CYC + Exp_Time*TICK_DIV + N_ROWS*ROW_CYC cycles.
- Done is high for exactly one cycle, coincident with the return to IDLE or ERASE.
- In continuous mode, Erase rises in the same cycle as Done. Phases have no gap cycles.
- Init held high in single-shot mode restarts on the edge after Done. IDLE therefore lasts exactly 1 cycle.
- Reset and Init both high: Reset wins.

## Structure
Shared package `exposure_pkg` holds:
- the state encoding: IDLE=2'b00, ERASE=2'b11, EXPOSE=2'b01, READOUT=2'b10;
- default parameter constants.

Sub-module `exp_time_reg` holds:
- the edge detectors;
- the saturating up/down register;
- an enable input driven by (state==IDLE).

The top level holds the FSM, the prescaler, the phase counter and the row/slot counters.

## Test plan
- Defaults, Init pulse: Erase high 4 cycles, Expose 8, NRE=2'b10 for 4 cycles then 2'b01 for 4, ADC high 2 cycles per row, Done at cycle 20.
- 30 Exp_Inc edges in IDLE: Exp_Time=30 (saturated). Then 30 Exp_Dec edges: Exp_Time=2. Simultaneous Inc+Dec: no change.
- Exp_Inc edge during EXPOSE: Exp_Time unchanged and current frame length unchanged.
- Cont=1 with Init held: back-to-back frames, Done then Erase in the same cycle, no IDLE cycle.
- Reset asserted at READOUT slot 1, k=2: next cycle NRE=all 1, ADC=0, Busy=0, Done=0, Exp_Time=2.
- N_ROWS=4, ROW_CYC=3, TICK_DIV=1, Exp_Time=5: Expose 5 cycles; NRE walks 1110, 1101, 1011, 0111; ADC once per row; Done at cycle 21.

Source files
------------

// File: rtl/exposure_pkg.sv
// Shared state encoding and default parameter values for the exposure sequencer.
package exposure_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ERASE   = 2'b11,
        S_EXPOSE  = 2'b01,
        S_READOUT = 2'b10
    } state_t;

    localparam int DEF_N_ROWS      = 2;
    localparam int DEF_EXP_W       = 5;
    localparam int DEF_EXP_MIN     = 2;
    localparam int DEF_EXP_MAX     = 30;
    localparam int DEF_EXP_DEFAULT = 2;
    localparam int DEF_EXP_STEP    = 1;
    localparam int DEF_TICK_DIV    = 4;
    localparam int DEF_ERASE_CYC   = 4;
    localparam int DEF_ROW_CYC     = 4;

endpackage

// File: rtl/exp_time_reg.sv
// Saturating exposure-time register stepped by rising edges of the Inc/Dec buttons,
// only while Enable is high.
module exp_time_reg #(
    parameter int EXP_W       = 5,
    parameter int EXP_MIN     = 2,
    parameter int EXP_MAX     = 30,
    parameter int EXP_DEFAULT = 2,
    parameter int EXP_STEP    = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Exp_Inc,
    input  logic             Exp_Dec,
    output logic [EXP_W-1:0] Exp_Time
);

    logic             inc_prev;
    logic             dec_prev;
    logic             inc_rise;
    logic             dec_rise;
    logic [EXP_W:0]   up_sum;
    logic [EXP_W:0]   dn_diff;
    logic [EXP_W-1:0] time_nx;

    assign inc_rise = Exp_Inc & ~inc_prev;
    assign dec_rise = Exp_Dec & ~dec_prev;

    // The extra top bit catches both overflow past EXP_MAX and borrow below zero.
    always_comb begin
        up_sum  = {1'b0, Exp_Time} + (EXP_W+1)'(EXP_STEP);
        dn_diff = {1'b0, Exp_Time} - (EXP_W+1)'(EXP_STEP);
        time_nx = Exp_Time;
        if (Enable && inc_rise && !dec_rise) begin
            time_nx = (up_sum > (EXP_W+1)'(EXP_MAX)) ? EXP_W'(EXP_MAX) : up_sum[EXP_W-1:0];
        end else if (Enable && dec_rise && !inc_rise) begin
            time_nx = (dn_diff[EXP_W] || (dn_diff < (EXP_W+1)'(EXP_MIN)))
                      ? EXP_W'(EXP_MIN) : dn_diff[EXP_W-1:0];
        end
    end

    // History bits reset high so a button held through reset does not step.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            inc_prev <= 1'b1;
            dec_prev <= 1'b1;
            Exp_Time <= EXP_W'(EXP_DEFAULT);
        end else begin
            inc_prev <= Exp_Inc;
            dec_prev <= Exp_Dec;
            Exp_Time <= time_nx;
        end
    end

endmodule

// File: rtl/exposure_sequencer.sv
// Sequences erase, exposure and row readout of the pixel array and strobes the ADC
// inside each row slot; all outputs are registered alongside the state.
module exposure_sequencer
    import exposure_pkg::*;
#(
    parameter int N_ROWS      = DEF_N_ROWS,
    parameter int EXP_W       = DEF_EXP_W,
    parameter int EXP_MIN     = DEF_EXP_MIN,
    parameter int EXP_MAX     = DEF_EXP_MAX,
    parameter int EXP_DEFAULT = DEF_EXP_DEFAULT,
    parameter int EXP_STEP    = DEF_EXP_STEP,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int ERASE_CYC   = DEF_ERASE_CYC,
    parameter int ROW_CYC     = DEF_ROW_CYC
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Init,
    input  logic              Cont,
    input  logic              Exp_Inc,
    input  logic              Exp_Dec,
    output logic              Erase,
    output logic              Expose,
    output logic [N_ROWS-1:0] NRE,
    output logic              ADC,
    output logic              Done,
    output logic              Busy,
    output logic [EXP_W-1:0]  Exp_Time
);

    localparam int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int SLOT_W = $clog2(ROW_CYC);
    localparam int PH_MAX = (ERASE_CYC > TICK_DIV) ? ERASE_CYC : TICK_DIV;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    state_t            state, state_nx;
    logic [PH_W-1:0]   phase_cnt, phase_nx;
    logic [EXP_W-1:0]  exp_cnt, exp_nx;
    logic [ROW_W-1:0]  row_cnt, row_nx;
    logic [SLOT_W-1:0] slot_cnt, slot_nx;
    logic              done_nx;

    exp_time_reg #(
        .EXP_W      (EXP_W),
        .EXP_MIN    (EXP_MIN),
        .EXP_MAX    (EXP_MAX),
        .EXP_DEFAULT(EXP_DEFAULT),
        .EXP_STEP   (EXP_STEP)
    ) u_exp_time (
        .Clk     (Clk),
        .Reset   (Reset),
        .Enable  (state == S_IDLE),
        .Exp_Inc (Exp_Inc),
        .Exp_Dec (Exp_Dec),
        .Exp_Time(Exp_Time)
    );

    // phase_cnt times the erase phase and doubles as the exposure prescaler;
    // exp_cnt counts remaining exposure units, latched on entry to EXPOSE.
    always_comb begin
        state_nx = state;
        phase_nx = phase_cnt;
        exp_nx   = exp_cnt;
        row_nx   = row_cnt;
        slot_nx  = slot_cnt;
        done_nx  = 1'b0;
        case (state)
            S_IDLE: begin
                if (Init) begin
                    state_nx = S_ERASE;
                    phase_nx = '0;
                end
            end
            S_ERASE: begin
                if (phase_cnt == PH_W'(ERASE_CYC - 1)) begin
                    state_nx = S_EXPOSE;
                    phase_nx = '0;
                    exp_nx   = Exp_Time;
                end else begin
                    phase_nx = phase_cnt + PH_W'(1);
                end
            end
            S_EXPOSE: begin
                if (phase_cnt == PH_W'(TICK_DIV - 1)) begin
                    phase_nx = '0;
                    if (exp_cnt <= EXP_W'(1)) begin
                        state_nx = S_READOUT;
                        row_nx   = '0;
                        slot_nx  = '0;
                    end else begin
                        exp_nx = exp_cnt - EXP_W'(1);
                    end
                end else begin
                    phase_nx = phase_cnt + PH_W'(1);
                end
            end
            S_READOUT: begin
                if (slot_cnt == SLOT_W'(ROW_CYC - 1)) begin
                    slot_nx = '0;
                    if (row_cnt == ROW_W'(N_ROWS - 1)) begin
                        row_nx   = '0;
                        phase_nx = '0;
                        done_nx  = 1'b1;
                        state_nx = Cont ? S_ERASE : S_IDLE;
                    end else begin
                        row_nx = row_cnt + ROW_W'(1);
                    end
                end else begin
                    slot_nx = slot_cnt + SLOT_W'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            phase_cnt <= '0;
            exp_cnt   <= '0;
            row_cnt   <= '0;
            slot_cnt  <= '0;
            Erase     <= 1'b0;
            Expose    <= 1'b0;
            NRE       <= '1;
            ADC       <= 1'b0;
            Done      <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            phase_cnt <= phase_nx;
            exp_cnt   <= exp_nx;
            row_cnt   <= row_nx;
            slot_cnt  <= slot_nx;
            Erase     <= (state_nx == S_ERASE);
            Expose    <= (state_nx == S_EXPOSE);
            NRE       <= (state_nx == S_READOUT) ? ~(N_ROWS'(1) << row_nx) : '1;
            ADC       <= (state_nx == S_READOUT) && (slot_nx != '0)
                         && (slot_nx != SLOT_W'(ROW_CYC - 1));
            Done      <= done_nx;
            Busy      <= (state_nx != S_IDLE);
        end
    end

endmodule

// File: tb/tb_exposure_sequencer.sv
// Self-checking bench: a frame-timeline reference model checks every cycle, plus a
// table of button/reset vectors and hand-written multi-cycle sequences.
module tb_exposure_sequencer;

    localparam int N_ROWS      = 2;
    localparam int EXP_W       = 5;
    localparam int EXP_MIN     = 2;
    localparam int EXP_MAX     = 30;
    localparam int EXP_DEFAULT = 2;
    localparam int EXP_STEP    = 1;
    localparam int TICK_DIV    = 4;
    localparam int ERASE_CYC   = 4;
    localparam int ROW_CYC     = 4;

    logic             clk;
    logic             reset, init, cont, expInc, expDec;
    logic             eraseOut, exposeOut, adcOut, doneOut, busyOut;
    logic [1:0]       nreOut;
    logic [4:0]       expTimeOut;

    // second instance: 4 rows, 3-cycle slots, no prescale, exposure 5 units
    logic             init2, cont2, inc2, dec2;
    logic             erase2, expose2, adc2, done2, busy2;
    logic [3:0]       nre2;
    logic [4:0]       expTime2;

    int nVec  = 0;
    int nFail = 0;
    int cycleNo = 0;

    // reference model: position of the current frame on its timeline
    bit mBusy, mDone, mIncPrev, mDecPrev;
    int mT, mExp, mFx;

    typedef struct {
        logic r, i, c, up, dn;
        int   expTime;
        logic expBusy;
    } vec_t;
    vec_t tbl[$];

    exposure_sequencer #(
        .N_ROWS(N_ROWS), .EXP_W(EXP_W), .EXP_MIN(EXP_MIN), .EXP_MAX(EXP_MAX),
        .EXP_DEFAULT(EXP_DEFAULT), .EXP_STEP(EXP_STEP), .TICK_DIV(TICK_DIV),
        .ERASE_CYC(ERASE_CYC), .ROW_CYC(ROW_CYC)
    ) dut (
        .Clk(clk), .Reset(reset), .Init(init), .Cont(cont),
        .Exp_Inc(expInc), .Exp_Dec(expDec),
        .Erase(eraseOut), .Expose(exposeOut), .NRE(nreOut), .ADC(adcOut),
        .Done(doneOut), .Busy(busyOut), .Exp_Time(expTimeOut)
    );

    exposure_sequencer #(
        .N_ROWS(4), .EXP_W(5), .EXP_MIN(2), .EXP_MAX(30), .EXP_DEFAULT(5),
        .EXP_STEP(1), .TICK_DIV(1), .ERASE_CYC(4), .ROW_CYC(3)
    ) dutAlt (
        .Clk(clk), .Reset(reset), .Init(init2), .Cont(cont2),
        .Exp_Inc(inc2), .Exp_Dec(dec2),
        .Erase(erase2), .Expose(expose2), .NRE(nre2), .ADC(adc2),
        .Done(done2), .Busy(busy2), .Exp_Time(expTime2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        nVec++;
        nFail++;
        $display("[TB] FAIL %s: bound expired", name);
    endtask

    // Model advances one clock edge with the inputs sampled at that edge.
    task automatic modelStep(input logic r, i, c, up, dn);
        bit incRise, decRise;
        if (r) begin
            mBusy = 0; mDone = 0; mT = 0;
            mExp = EXP_DEFAULT; mFx = EXP_DEFAULT;
            mIncPrev = 1; mDecPrev = 1;
            return;
        end
        incRise  = up && !mIncPrev;
        decRise  = dn && !mDecPrev;
        mIncPrev = up;
        mDecPrev = dn;
        mDone    = 0;
        if (!mBusy) begin
            if (incRise && !decRise)
                mExp = (mExp + EXP_STEP > EXP_MAX) ? EXP_MAX : mExp + EXP_STEP;
            else if (decRise && !incRise)
                mExp = (mExp - EXP_STEP < EXP_MIN) ? EXP_MIN : mExp - EXP_STEP;
            if (i) begin
                mBusy = 1;
                mT    = 0;
            end
        end else begin
            mT++;
            if (mT == ERASE_CYC) mFx = mExp;
            if (mT == ERASE_CYC + mFx * TICK_DIV + N_ROWS * ROW_CYC) begin
                mDone = 1;
                mT    = 0;
                mBusy = c;
            end
        end
    endtask

    function automatic logic [11:0] modelOutputs();
        logic       er, ex, ad;
        logic [1:0] nr;
        int         exposeEnd, u, k;
        er = 0; ex = 0; ad = 0; nr = 2'b11;
        if (mBusy) begin
            exposeEnd = ERASE_CYC + mFx * TICK_DIV;
            if (mT < ERASE_CYC) er = 1;
            else if (mT < exposeEnd) ex = 1;
            else begin
                u  = mT - exposeEnd;
                k  = u % ROW_CYC;
                nr = ~(2'(1) << (u / ROW_CYC));
                ad = (k >= 1) && (k <= ROW_CYC - 2);
            end
        end
        return {er, ex, nr, ad, logic'(mDone), logic'(mBusy), 5'(mExp)};
    endfunction

    function automatic logic [11:0] actualOutputs();
        return {eraseOut, exposeOut, nreOut, adcOut, doneOut, busyOut, expTimeOut};
    endfunction

    // Drive inputs on the falling edge, step the model, check #1 after the rising edge.
    task automatic applyStimulus(input logic r, i, c, up, dn, input string tag);
        @(negedge clk);
        reset = r; init = i; cont = c; expInc = up; expDec = dn;
        modelStep(r, i, c, up, dn);
        @(posedge clk);
        #1;
        cycleNo++;
        checkOutput($sformatf("%s model@%0d", tag, cycleNo), 32'(actualOutputs()), 32'(modelOutputs()));
    endtask

    function automatic vec_t mk(input logic r, i, c, up, dn, input int e, input logic b);
        vec_t v;
        v.r = r; v.i = i; v.c = c; v.up = up; v.dn = dn; v.expTime = e; v.expBusy = b;
        return v;
    endfunction

    // One single-shot frame from IDLE, optionally pulsing Exp_Inc mid-frame.
    task automatic runFrame(input int incAt, output int lat, output int eraseN, output int exposeN,
                            output int adcN, output int nreHiN, output int nreLoN);
        lat = 0; eraseN = 0; exposeN = 0; adcN = 0; nreHiN = 0; nreLoN = 0;
        applyStimulus(0, 1, 0, 0, 0, "frame");
        while (!doneOut && lat < 100) begin
            eraseN  += int'(eraseOut);
            exposeN += int'(exposeOut);
            adcN    += int'(adcOut);
            nreHiN  += int'(nreOut == 2'b10);
            nreLoN  += int'(nreOut == 2'b01);
            applyStimulus(0, 0, 0, logic'(lat == incAt), 0, "frame");
            lat++;
        end
        if (!doneOut) failNow("frame done");
    endtask

    initial begin
        int lat, eraseN, exposeN, adcN, nreHiN, nreLoN;
        int doneN, badDone, idleN, bound, e;
        int lat2, expose2N, adc2N;
        logic [3:0] walk[$];
        logic [3:0] walkExp [4];
        logic [3:0] got;

        reset = 1; init = 0; cont = 0; expInc = 0; expDec = 0;
        init2 = 0; cont2 = 0; inc2 = 0; dec2 = 0;
        walkExp = '{4'hE, 4'hD, 4'hB, 4'h7};

        // button table: held through reset, saturate up, saturate down, simultaneous edges
        tbl.push_back(mk(1, 0, 0, 1, 0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0));
        for (int n = 1; n <= 30; n++) begin
            e = (2 + n > 30) ? 30 : 2 + n;
            tbl.push_back(mk(0, 0, 0, 1, 0, e, 0));
            tbl.push_back(mk(0, 0, 0, 0, 0, e, 0));
        end
        for (int n = 1; n <= 30; n++) begin
            e = (30 - n < 2) ? 2 : 30 - n;
            tbl.push_back(mk(0, 0, 0, 0, 1, e, 0));
            tbl.push_back(mk(0, 0, 0, 0, 0, e, 0));
        end
        tbl.push_back(mk(0, 0, 0, 1, 1, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 3, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0));

        foreach (tbl[n]) begin
            applyStimulus(tbl[n].r, tbl[n].i, tbl[n].c, tbl[n].up, tbl[n].dn, "tbl");
            checkOutput($sformatf("tbl%0d exp_time", n), 32'(expTimeOut), 32'(tbl[n].expTime));
            checkOutput($sformatf("tbl%0d busy", n), 32'(busyOut), 32'(tbl[n].expBusy));
        end

        // default frame timing
        runFrame(-1, lat, eraseN, exposeN, adcN, nreHiN, nreLoN);
        checkOutput("frame latency", lat, 20);
        checkOutput("frame erase cycles", eraseN, 4);
        checkOutput("frame expose cycles", exposeN, 8);
        checkOutput("frame adc cycles", adcN, 4);
        checkOutput("frame nre 10 cycles", nreHiN, 4);
        checkOutput("frame nre 01 cycles", nreLoN, 4);
        applyStimulus(0, 0, 0, 0, 0, "idle");

        // Exp_Inc edge during EXPOSE is discarded
        runFrame(5, lat, eraseN, exposeN, adcN, nreHiN, nreLoN);
        checkOutput("inc-in-expose latency", lat, 20);
        checkOutput("inc-in-expose expose cycles", exposeN, 8);
        checkOutput("inc-in-expose exp_time", 32'(expTimeOut), 2);
        applyStimulus(0, 0, 0, 0, 0, "idle");

        // continuous back-to-back frames
        doneN = 0; badDone = 0; idleN = 0;
        for (int n = 0; n < 65; n++) begin
            applyStimulus(0, 1, 1, 0, 0, "cont");
            if (doneOut) begin
                doneN++;
                if (!eraseOut || !busyOut) badDone++;
            end
            if (!busyOut) idleN++;
        end
        checkOutput("cont done count", doneN, 3);
        checkOutput("cont done without erase", badDone, 0);
        checkOutput("cont idle cycles", idleN, 0);
        bound = 0;
        do begin
            applyStimulus(0, 0, 0, 0, 0, "cont end");
            bound++;
        end while (!doneOut && bound < 100);
        if (!doneOut) failNow("cont end done");
        applyStimulus(0, 0, 0, 0, 0, "idle");

        // reset during READOUT slot 1, k=2
        applyStimulus(0, 1, 0, 0, 0, "rst");
        for (int n = 0; n < 18; n++) applyStimulus(0, 0, 0, 0, 0, "rst");
        checkOutput("rst pre nre", 32'(nreOut), 32'(2'b01));
        checkOutput("rst pre adc", 32'(adcOut), 1);
        applyStimulus(1, 0, 0, 0, 0, "rst");
        checkOutput("rst post outputs", 32'({nreOut, adcOut, busyOut, doneOut, expTimeOut}),
                    32'({2'b11, 1'b0, 1'b0, 1'b0, 5'd2}));
        applyStimulus(0, 0, 0, 0, 0, "idle");

        // alternate configuration frame
        lat2 = 0; expose2N = 0; adc2N = 0;
        init2 = 1;
        applyStimulus(0, 0, 0, 0, 0, "alt");
        init2 = 0;
        while (!done2 && lat2 < 100) begin
            expose2N += int'(expose2);
            adc2N    += int'(adc2);
            if (nre2 != 4'hF && (walk.size() == 0 || walk[$] != nre2)) walk.push_back(nre2);
            applyStimulus(0, 0, 0, 0, 0, "alt");
            lat2++;
        end
        if (!done2) failNow("alt done");
        checkOutput("alt latency", lat2, 21);
        checkOutput("alt expose cycles", expose2N, 5);
        checkOutput("alt adc cycles", adc2N, 4);
        checkOutput("alt nre walk length", walk.size(), 4);
        for (int n = 0; n < 4; n++) begin
            got = (n < walk.size()) ? walk[n] : 4'h0;
            checkOutput($sformatf("alt nre walk %0d", n), 32'(got), 32'(walkExp[n]));
        end
        applyStimulus(0, 0, 0, 0, 0, "idle");

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(logic'($urandom_range(0, 99) == 0), logic'($urandom_range(0, 3) == 0),
                          logic'($urandom_range(0, 1)), logic'($urandom_range(0, 2) == 0),
                          logic'($urandom_range(0, 2) == 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
